// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes, fault causes and store formatting helpers
// for the load/store stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response port: single outstanding request, read data
// returned on a separate valid strobe.
interface lsu_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, addr, we, wstrb, wdata,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, we, wstrb, wdata,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LBU:     data = {24'h0, byte_sel};
            LHU:     data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: single-outstanding memory transaction, load alignment,
// registered writeback record and fault reporting.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rs2_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              lsu_stall,
    lsu_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [31:0]       wb_data,
    output logic              lsu_fault,
    output logic [1:0]        fault_cause,
    output logic [31:0]       fault_addr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [31:0]    lat_addr, lat_wdata;
    logic [3:0]     lat_wstrb;
    logic           lat_we, lat_rw;
    logic [2:0]     lat_f3;
    logic [4:0]     lat_rd;

    logic           latch, wb_fire, fault_fire;
    logic [4:0]     wb_rd_n;
    logic           wb_rw_n;
    logic [31:0]    wb_data_n, fault_addr_n, load_data;
    logic [1:0]     cause_n;
    logic           f3_ok, illegal, misaligned, in_req;

    lsu_load_align u_align (
        .rdata  (dmem.rdata),
        .offset (lat_addr[1:0]),
        .funct3 (lat_f3),
        .data   (load_data)
    );

    assign in_req         = (state == REQ);
    assign lsu_stall      = (state != IDLE);
    assign dmem.req_valid = in_req;
    assign dmem.addr      = in_req ? {lat_addr[31:2], 2'b00} : '0;
    assign dmem.we        = in_req & lat_we;
    assign dmem.wstrb     = in_req ? lat_wstrb : '0;
    assign dmem.wdata     = in_req ? lat_wdata : '0;

    always_comb begin
        f3_ok = ex_mem_write ? (ex_funct3 inside {SB, SH, SW})
                             : (ex_funct3 inside {LB, LH, LW, LBU, LHU});
        illegal    = (ex_mem_read & ex_mem_write) | ~f3_ok;
        misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_out[0]) |
                     ((ex_funct3[1:0] == 2'b10) & (ex_alu_out[1:0] != 2'b00));
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        latch        = 1'b0;
        wb_fire      = 1'b0;
        wb_rd_n      = wb_rd;
        wb_rw_n      = wb_reg_write;
        wb_data_n    = wb_data;
        fault_fire   = 1'b0;
        cause_n      = fault_cause;
        fault_addr_n = fault_addr;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    wb_rd_n = ex_rd;
                    if (!(ex_mem_read | ex_mem_write)) begin
                        wb_fire   = 1'b1;
                        wb_rw_n   = ex_reg_write;
                        wb_data_n = ex_alu_out;
                    end else if (illegal | misaligned) begin
                        wb_fire      = 1'b1;
                        wb_rw_n      = 1'b0;
                        fault_fire   = 1'b1;
                        cause_n      = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        fault_addr_n = ex_alu_out;
                    end else begin
                        wb_rd_n = wb_rd;
                        latch   = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.req_ready) begin
                    if (lat_we) begin
                        wb_fire = 1'b1;
                        wb_rd_n = lat_rd;
                        wb_rw_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = '0;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (dmem.resp_valid) begin
                    wb_fire   = 1'b1;
                    wb_rd_n   = lat_rd;
                    wb_rw_n   = lat_rw;
                    wb_data_n = load_data;
                    state_n   = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    wb_fire      = 1'b1;
                    wb_rd_n      = lat_rd;
                    wb_rw_n      = 1'b0;
                    fault_fire   = 1'b1;
                    cause_n      = CAUSE_TIMEOUT;
                    fault_addr_n = lat_addr;
                    state_n      = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_wstrb    <= '0;
            lat_we       <= 1'b0;
            lat_rw       <= 1'b0;
            lat_f3       <= '0;
            lat_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            lsu_fault    <= 1'b0;
            fault_cause  <= '0;
            fault_addr   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            wb_valid     <= wb_fire;
            wb_rd        <= wb_rd_n;
            wb_reg_write <= wb_rw_n;
            wb_data      <= wb_data_n;
            lsu_fault    <= fault_fire;
            fault_cause  <= cause_n;
            fault_addr   <= fault_addr_n;
            if (latch) begin
                lat_addr  <= ex_alu_out;
                lat_wdata <= store_wdata(ex_funct3, ex_rs2_data);
                lat_wstrb <= ex_mem_write ? store_wstrb(ex_funct3, ex_alu_out[1:0]) : '0;
                lat_we    <= ex_mem_write;
                lat_rw    <= ex_reg_write;
                lat_f3    <= ex_funct3;
                lat_rd    <= ex_rd;
            end
        end
    end

endmodule
